// File: rtl/rv523_clk_pkg.sv
// Shared types and limits for the two-phase clock generator: FSM state enum,
// dwell-length limits and the 4-bit dwell counter width.
package rv523_clk_pkg;

  localparam int CYC_MIN = 1;
  localparam int CYC_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD1 = 3'd1,
    PH1   = 3'd2,
    DEAD2 = 3'd3,
    PH2   = 3'd4
  } phaseState_e;

  // A state that lasts N cycles is entered with N-1 and left when the count is zero.
  function automatic logic [CNT_W-1:0] dwellLoad(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: loads on state entry, counts down to zero and holds there.
module dwell_counter
  import rv523_clk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] loadVal,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/two_phase_clkgen.sv
// Non-overlapping two-phase latch-enable generator: DEAD1 -> PH1 -> DEAD2 -> PH2.
// Define TWO_PHASE_CLKGEN_STEP_EN to let a STEP pulse in IDLE run one full cycle.
module two_phase_clkgen
  import rv523_clk_pkg::*;
#(
  parameter int DEAD_CYC = 1,
  parameter int PH_CYC   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP,
  output logic             PHI1,
  output logic             nPHI1,
  output logic             PHI2,
  output logic             nPHI2,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       dbgState,
  output logic [CNT_W-1:0] dbgCount
);

  if ((DEAD_CYC < CYC_MIN) || (DEAD_CYC > CYC_MAX)) begin : gBadDeadCyc
    $error("two_phase_clkgen: DEAD_CYC must be in 1..15");
  end
  if ((PH_CYC < CYC_MIN) || (PH_CYC > CYC_MAX)) begin : gBadPhCyc
    $error("two_phase_clkgen: PH_CYC must be in 1..15");
  end

  localparam logic [CNT_W-1:0] DEAD_LOAD = dwellLoad(DEAD_CYC);
  localparam logic [CNT_W-1:0] PH_LOAD   = dwellLoad(PH_CYC);

  phaseState_e      state;
  phaseState_e      stateNext;
  logic             cntLoad;
  logic             cntDec;
  logic [CNT_W-1:0] cntLoadVal;
  logic [CNT_W-1:0] cntValue;
  logic             cntZero;
  logic             doneNext;
  logic             startReq;

  // RUN is a level sampled in IDLE and at the end of PH2; STEP is a one-cycle
  // request honoured only in IDLE, never queued while a cycle is in flight.
`ifdef TWO_PHASE_CLKGEN_STEP_EN
  assign startReq = RUN | STEP;
`else
  logic unusedStep;
  assign unusedStep = STEP;
  assign startReq   = RUN;
`endif

  dwell_counter uDwell (
    .clk     (CLK),
    .rst     (RST),
    .load    (cntLoad),
    .dec     (cntDec),
    .loadVal (cntLoadVal),
    .count   (cntValue),
    .zero    (cntZero)
  );

  always_comb begin
    stateNext  = state;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLoadVal = '0;
    doneNext   = 1'b0;
    case (state)
      IDLE: begin
        if (startReq) begin
          stateNext  = DEAD1;
          cntLoad    = 1'b1;
          cntLoadVal = DEAD_LOAD;
        end
      end
      DEAD1: begin
        if (cntZero) begin
          stateNext  = PH1;
          cntLoad    = 1'b1;
          cntLoadVal = PH_LOAD;
        end else begin
          cntDec = 1'b1;
        end
      end
      PH1: begin
        if (cntZero) begin
          stateNext  = DEAD2;
          cntLoad    = 1'b1;
          cntLoadVal = DEAD_LOAD;
        end else begin
          cntDec = 1'b1;
        end
      end
      DEAD2: begin
        if (cntZero) begin
          stateNext  = PH2;
          cntLoad    = 1'b1;
          cntLoadVal = PH_LOAD;
        end else begin
          cntDec = 1'b1;
        end
      end
      PH2: begin
        if (cntZero) begin
          doneNext = 1'b1;
          cntLoad  = 1'b1;
          if (RUN) begin
            stateNext  = DEAD1;
            cntLoadVal = DEAD_LOAD;
          end else begin
            stateNext  = IDLE;
            cntLoadVal = '0;
          end
        end else begin
          cntDec = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntLoad   = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      PHI1  <= 1'b0;
      nPHI1 <= 1'b1;
      PHI2  <= 1'b0;
      nPHI2 <= 1'b1;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= stateNext;
      PHI1  <= (stateNext == PH1);
      nPHI1 <= (stateNext != PH1);
      PHI2  <= (stateNext == PH2);
      nPHI2 <= (stateNext != PH2);
      BUSY  <= (stateNext != IDLE);
      DONE  <= doneNext;
    end
  end

  assign dbgState = state;
  assign dbgCount = cntValue;

endmodule

// File: tb/tb_two_phase_clkgen.sv
// Bench for two_phase_clkgen: default (1,2) and (3,1) instances share stimulus and
// are checked every cycle against a cycle-position model, plus vector table and corner sequences.
module tb_two_phase_clkgen;

`ifdef TWO_PHASE_CLKGEN_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic RST  = 1'b1;
  logic RUN  = 1'b0;
  logic STEP = 1'b0;

  logic       phi1[2];
  logic       nphi1[2];
  logic       phi2[2];
  logic       nphi2[2];
  logic       busy[2];
  logic       done[2];
  logic [2:0] dbgState[2];
  logic [3:0] dbgCount[2];

  int nChecks = 0;
  int nFails  = 0;
  int tickNo  = 0;

  // model: active flag and position inside the 2*(D+P) cycle
  int act[2];
  int pos[2];
  int dn[2];

  always #5 CLK = ~CLK;

  two_phase_clkgen #(.DEAD_CYC(1), .PH_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP),
    .PHI1(phi1[0]), .nPHI1(nphi1[0]), .PHI2(phi2[0]), .nPHI2(nphi2[0]),
    .BUSY(busy[0]), .DONE(done[0]), .dbgState(dbgState[0]), .dbgCount(dbgCount[0])
  );

  two_phase_clkgen #(.DEAD_CYC(3), .PH_CYC(1)) dut31 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP),
    .PHI1(phi1[1]), .nPHI1(nphi1[1]), .PHI2(phi2[1]), .nPHI2(nphi2[1]),
    .BUSY(busy[1]), .DONE(done[1]), .dbgState(dbgState[1]), .dbgCount(dbgCount[1])
  );

  function automatic int dcOf(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int pcOf(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int periodOf(int k);
    return 2 * (dcOf(k) + pcOf(k));
  endfunction

  function automatic int maxDwellOf(int k);
    return ((dcOf(k) > pcOf(k)) ? dcOf(k) : pcOf(k)) - 1;
  endfunction

  task automatic check(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s inst%0d tick%0d: got %0d expected %0d", name, k, tickNo, got, exp);
    end
  endtask

  task automatic modelStep(input int k);
    if (RST) begin
      act[k] = 0; pos[k] = 0; dn[k] = 0;
    end else if (act[k] == 0) begin
      dn[k] = 0;
      if (RUN || (STEP_EN && STEP)) begin
        act[k] = 1; pos[k] = 0;
      end
    end else if (pos[k] == periodOf(k) - 1) begin
      dn[k]  = 1;
      pos[k] = 0;
      if (!RUN) act[k] = 0;
    end else begin
      dn[k] = 0;
      pos[k]++;
    end
  endtask

  task automatic tick();
    logic ep1, ep2;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) modelStep(k);
    #1;
    tickNo++;
    for (int k = 0; k < 2; k++) begin
      ep1 = (act[k] != 0) && (pos[k] >= dcOf(k)) && (pos[k] < dcOf(k) + pcOf(k));
      ep2 = (act[k] != 0) && (pos[k] >= 2 * dcOf(k) + pcOf(k));
      check("phi1_model", k, {7'd0, phi1[k]}, {7'd0, ep1});
      check("phi2_model", k, {7'd0, phi2[k]}, {7'd0, ep2});
      check("busy_model", k, {7'd0, busy[k]}, {7'd0, act[k] != 0});
      check("done_model", k, {7'd0, done[k]}, {7'd0, dn[k] != 0});
      check("nphi1_compl", k, {7'd0, nphi1[k]}, {7'd0, ~phi1[k]});
      check("nphi2_compl", k, {7'd0, nphi2[k]}, {7'd0, ~phi2[k]});
      check("no_overlap", k, {7'd0, phi1[k] & phi2[k]}, 8'd0);
      check("cnt_no_wrap", k, {7'd0, dbgCount[k] <= 4'(maxDwellOf(k))}, 8'd1);
      if (act[k] == 0) begin
        check("idle_cnt_zero", k, {4'd0, dbgCount[k]}, 8'd0);
        check("idle_state", k, {5'd0, dbgState[k]}, 8'd0);
      end
    end
  endtask

  typedef struct {
    logic rst;
    logic run;
    logic p1;
    logic p2;
    logic bsy;
    logic dne;
  } vec_t;

  vec_t vecs[24];

  task automatic setVec(input int i, input logic rst, input logic run, input logic p1,
                        input logic p2, input logic bsy, input logic dne);
    vecs[i] = '{rst, run, p1, p2, bsy, dne};
  endtask

  initial begin
    int lastRise[2];
    logic prevP1[2];
    int p1Rises, p2Rises, doneCnt, busyCnt, stepInjected;
    logic prevP2;

    // rst run | phi1 phi2 busy done  (default instance)
    setVec(0, 1, 0, 0, 0, 0, 0);  setVec(1, 1, 0, 0, 0, 0, 0);
    setVec(2, 0, 1, 0, 0, 1, 0);  setVec(3, 0, 1, 1, 0, 1, 0);
    setVec(4, 0, 1, 1, 0, 1, 0);  setVec(5, 0, 0, 0, 0, 1, 0);
    setVec(6, 0, 0, 0, 1, 1, 0);  setVec(7, 0, 0, 0, 1, 1, 0);
    setVec(8, 0, 0, 0, 0, 0, 1);  setVec(9, 0, 0, 0, 0, 0, 0);
    setVec(10, 0, 1, 0, 0, 1, 0); setVec(11, 0, 1, 1, 0, 1, 0);
    setVec(12, 0, 1, 1, 0, 1, 0); setVec(13, 0, 1, 0, 0, 1, 0);
    setVec(14, 0, 1, 0, 1, 1, 0); setVec(15, 0, 1, 0, 1, 1, 0);
    setVec(16, 0, 1, 0, 0, 1, 1); setVec(17, 0, 1, 1, 0, 1, 0);
    setVec(18, 0, 1, 1, 0, 1, 0); setVec(19, 0, 1, 0, 0, 1, 0);
    setVec(20, 0, 1, 0, 1, 1, 0); setVec(21, 0, 1, 0, 1, 1, 0);
    setVec(22, 1, 1, 0, 0, 0, 0); setVec(23, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      RST = vecs[i].rst; RUN = vecs[i].run; STEP = 1'b0;
      tick();
      check("vec_phi1", i, {7'd0, phi1[0]}, {7'd0, vecs[i].p1});
      check("vec_phi2", i, {7'd0, phi2[0]}, {7'd0, vecs[i].p2});
      check("vec_busy", i, {7'd0, busy[0]}, {7'd0, vecs[i].bsy});
      check("vec_done", i, {7'd0, done[0]}, {7'd0, vecs[i].dne});
      if (vecs[i].rst) check("vec_rst_cnt", i, {4'd0, dbgCount[0]}, 8'd0);
    end

    // Continuous RUN: PHI1 rise spacing equals the period on both instances.
    RST = 1'b1; RUN = 1'b0; tick(); tick();
    RST = 1'b0; RUN = 1'b1;
    lastRise = '{-1, -1};
    prevP1   = '{1'b0, 1'b0};
    for (int t = 0; t < 40; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (phi1[k] && !prevP1[k]) begin
          if (lastRise[k] >= 0) check("period", k, 8'(tickNo - lastRise[k]), 8'(periodOf(k)));
          lastRise[k] = tickNo;
        end
        prevP1[k] = phi1[k];
      end
    end
    check("period_seen", 0, {7'd0, lastRise[0] >= 0}, 8'd1);
    check("period_seen", 1, {7'd0, lastRise[1] >= 0}, 8'd1);
    RUN = 1'b0;
    for (int t = 0; t < 10; t++) tick();

    // STEP in IDLE, second STEP during PH1 must not add a cycle.
    RST = 1'b1; tick(); RST = 1'b0;
    STEP = 1'b1; tick(); STEP = 1'b0;
    p1Rises = 0; p2Rises = 0; doneCnt = 0; busyCnt = 0; stepInjected = 0;
    prevP1[0] = 1'b0; prevP2 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      if (phi1[0] && stepInjected == 0) begin
        STEP = 1'b1; stepInjected = 1;
      end else begin
        STEP = 1'b0;
      end
      if (phi1[0] && !prevP1[0]) p1Rises++;
      if (phi2[0] && !prevP2) p2Rises++;
      if (done[0]) doneCnt++;
      if (busy[0]) busyCnt++;
      prevP1[0] = phi1[0]; prevP2 = phi2[0];
      tick();
    end
    STEP = 1'b0;
    check("step_phi1_pulses", 0, 8'(p1Rises), {7'd0, STEP_EN});
    check("step_phi2_pulses", 0, 8'(p2Rises), {7'd0, STEP_EN});
    check("step_done_pulses", 0, 8'(doneCnt), {7'd0, STEP_EN});
    check("step_busy_cycles", 0, 8'(busyCnt), STEP_EN ? 8'd6 : 8'd0);
    check("step_end_idle", 0, {7'd0, busy[0]}, 8'd0);

    // RUN and STEP together: cycling continues past one period.
    RUN = 1'b1; STEP = 1'b1; tick(); STEP = 1'b0;
    for (int t = 0; t < 13; t++) tick();
    check("run_step_continuous", 0, {7'd0, busy[0]}, 8'd1);
    RUN = 1'b0;
    for (int t = 0; t < 10; t++) tick();

    // Randomized stimulus against the model.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 7) == 0) RUN = ~RUN;
      STEP = ($urandom_range(0, 5) == 0);
      RST  = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/two_phase_clkgen.md
TWO_PHASE_CLKGEN -- requirements
Module: two_phase_clkgen

Interface
REQ-001 Parameter DEAD_CYC, default 1: dead-time length in CLK cycles, both phases low; legal range 1..15.
REQ-002 Parameter PH_CYC, default 2: active length of each phase in CLK cycles; legal range 1..15.
REQ-003 Single clock CLK and synchronous active-high reset RST; no other clock or reset exists.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 RUN  input  1  level; request continuous two-phase cycling.
REQ-007 STEP  input  1  single-cycle pulse; request exactly one full phase cycle.
REQ-008 PHI1  output  1  phase-1 latch enable.
REQ-009 nPHI1  output  1  complement of PHI1.
REQ-010 PHI2  output  1  phase-2 latch enable.
REQ-011 nPHI2  output  1  complement of PHI2.
REQ-012 BUSY  output  1  high whenever state is not IDLE.
REQ-013 DONE  output  1  one-cycle pulse marking completion of a PH2 phase.

Function
REQ-014 States: IDLE, DEAD1, PH1, DEAD2, PH2; all outputs are registered.
REQ-015 PHI1 SHALL be high only in PH1 and PHI2 only in PH2; PHI1 and PHI2 SHALL never be high in the same cycle.
REQ-016 nPHI1 and nPHI2 SHALL be the exact complements of PHI1 and PHI2 in every cycle, with no skew cycle.
REQ-017 IDLE with RUN=1 SHALL go to DEAD1 on the next edge.
REQ-018 DEAD1 and DEAD2 SHALL last DEAD_CYC cycles each; PH1 and PH2 SHALL last PH_CYC cycles each.
REQ-019 Transition sequence: DEAD1->PH1->DEAD2->PH2.
REQ-020 At the end of PH2: RUN=1 -> DEAD1; otherwise -> IDLE.
REQ-021 The period SHALL be 2*(DEAD_CYC+PH_CYC) cycles.
REQ-022 RUN deasserted mid-cycle SHALL NOT truncate any phase; the current cycle completes through PH2.
REQ-023 DONE SHALL be high for exactly the one cycle after the last PH2 cycle.
REQ-024 STEP in IDLE with RUN=0 SHALL run one cycle (DEAD1..PH2), then return to IDLE.
REQ-025 STEP while BUSY=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 RUN and STEP asserted together in IDLE: RUN wins and cycling is continuous.
REQ-027 The dwell counter SHALL be 4 bits, SHALL load on each state entry and SHALL count down to zero; it SHALL never wrap.

Reset
REQ-028 RST SHALL take precedence over all inputs, including mid-phase.
REQ-029 One cycle after RST: state IDLE, counter 0, PHI1=0, PHI2=0, nPHI1=1, nPHI2=1, BUSY=0, DONE=0.
REQ-030 Reset asserted during PH1 or PH2 SHALL drop that phase in the next cycle with no glitch to the other phase.

Configuration
REQ-031 Macro TWO_PHASE_CLKGEN_STEP_EN compiles in single-step support.
REQ-032 With TWO_PHASE_CLKGEN_STEP_EN defined: REQ-024..REQ-026 apply.
REQ-033 Without TWO_PHASE_CLKGEN_STEP_EN: the STEP port SHALL remain present but be ignored, and only RUN starts cycling.

Structure
REQ-034 Shared package rv523_clk_pkg SHALL hold the state enum and the DEAD_CYC/PH_CYC limit constants (MAX 15, counter width 4).
REQ-035 The dwell counter SHALL be one sub-module, dwell_counter (load, decrement, zero flag).
REQ-036 An elaboration check SHALL reject DEAD_CYC or PH_CYC outside 1..15.

Verification
REQ-037 Defaults, RST for 2 cycles, then RUN=1 held: the first PHI1 rises 2 cycles after RUN, PHI1 is high 2 cycles, and the period is 6 cycles.
REQ-038 RUN=1 for 3 cycles then 0: exactly one full cycle, DONE pulses once, BUSY falls with DONE, and the outputs return to idle values.
REQ-039 STEP pulse in IDLE (macro defined): one PHI1 pulse and one PHI2 pulse occur; a second STEP during PH1 produces no extra cycle.
REQ-040 RST asserted in the 2nd cycle of PH2: next cycle PHI2=0, nPHI2=1, BUSY=0, and PHI1 stays 0.
REQ-041 DEAD_CYC=3, PH_CYC=1: the period is 8 cycles, and every cycle is checked for no PHI1&PHI2 overlap and for nPHIx==~PHIx.
REQ-042 Macro undefined, STEP pulses with RUN=0: BUSY stays 0 and the outputs stay at reset values.
